fetch_npc_unit: RTL and testbench
=================================

Name: fetch_npc_unit

Overview:
- Instruction fetch and next-PC stage: holds the PC, fetches each instruction from instruction memory over a req/ready handshake, and presents it to the decoder/datapath for one execute window.
- At the end of that window it updates the PC from the controller's 3-bit nPC_sel, the ALU zero flag and the rs register value.
- Also produces the jal link value and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset (byte address, word aligned).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of requested word; equals pc.
- imem_ready  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered current instruction.
- instr_valid  out  1  high during the execute window; datapath commits only when high.
- stall  in  1  hold the execute window; PC is not updated.
- nPC_sel  in  3  000 seq, 001 beq, 010 bne, 011 j, 100 jal, 101 jr; 110/111 treated as seq.
- zero  in  1  ALU zero flag for the current instruction.
- rs_data  in  32  register rs value, used by jr.
- pc  out  32  PC of current instruction.
- pc_plus4  out  32  pc+4; jal link value.
- retired  out  CNT_W  count of committed instructions.
- halted  out  1  sticky: a misaligned next PC was detected.

Behaviour:
- Reset: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, halted=0, state=S_REQ. Reset overrides everything, mid-fetch included; a pending imem_ready in the reset cycle is ignored.
- FSM states S_REQ, S_EXEC, S_HALT.
- S_REQ: imem_req=1, imem_addr=pc.
  - imem_ready=1: instr<=imem_rdata, go S_EXEC.
  - Otherwise stay, holding request and address stable.
- S_EXEC: imem_req=0, instr_valid=1. Default 1 cycle.
  - stall=1: stay in S_EXEC, pc/instr held.
  - stall=0 and npc[1:0]!=0: halted<=1, go S_HALT, pc unchanged, retired unchanged.
  - stall=0 and npc[1:0]==0: pc<=npc, retired<=retired+1 (wraps), go S_REQ.
- S_HALT: absorbing until reset; imem_req=0, instr_valid=0.
- Fetch latency: minimum 2 cycles per instruction (1 req + 1 exec) when imem_ready is high in the first S_REQ cycle.
- npc (combinational, 32-bit, mod 2^32):
  - seq: pc+4.
  - beq: zero ? pc+4+(sext(instr[15:0])<<2) : pc+4.
  - bne: !zero ? branch target : pc+4.
  - j and jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jr: rs_data.
- pc_plus4 is valid in every state and is used as the link value on jal commit.
- Wrap-around: pc=32'hFFFF_FFFC sequential gives 0. Negative branch offsets below 0 wrap.
- The only possible misalignment source is jr (other targets are aligned by construction).

Decomposition:
- Shared package: nPC_sel encodings (NPC_SEQ..NPC_JR), FSM state encodings, RESET_PC default.
- Sub-module npc_calc: purely combinational, inputs pc, instr, nPC_sel, zero, rs_data; outputs npc and pc_plus4.

Test Plan:
- Reset then imem_ready tied high, sequential nPC_sel=000 for 3 instructions: imem_addr goes 3000, 3004, 3008; retired=3 after 6 cycles.
- beq with instr[15:0]=16'hFFFF: zero=1 at pc=3010 gives next fetch 3010; zero=0 gives 3014. bne with offset 2: zero=0 gives 301C.
- jal at pc=3020 with instr[25:0]=26'h0000C40: pc_plus4=3024 in exec, next pc=00003100. jr with rs_data=3024 gives next pc 3024.
- imem_ready low for 3 cycles: imem_req and addr held stable. Then stall high 2 cycles in S_EXEC: pc, instr, retired unchanged; instr_valid stays 1.
- jr with rs_data=32'h0000_3002: halted=1, pc unchanged, imem_req stays 0. Reset asserted in S_HALT: pc=3000, halted=0, fetch resumes.
- Reset asserted while in S_REQ with imem_ready=1: instr stays 0, pc=RESET_PC, retired=0.

Source files
------------

// File: rtl/fetch_npc_unit_pkg.sv
// Shared definitions for the fetch / next-PC stage.
//   - npc_sel_e     : controller next-PC select encodings
//   - fetch_state_e : fetch FSM state encodings
//   - RESET_PC_DEFAULT : default PC after reset
package fetch_npc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [2:0] {
    NPC_SEQ = 3'b000,
    NPC_BEQ = 3'b001,
    NPC_BNE = 3'b010,
    NPC_J   = 3'b011,
    NPC_JAL = 3'b100,
    NPC_JR  = 3'b101
  } npc_sel_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// Combinational next-PC calculator.
// Inputs : pc, instr, nPC_sel, zero, rs_data
// Outputs: npc (next PC candidate, mod 2^32), pc_plus4 (sequential PC / jal link)
module fetch_npc_unit_npc_calc
  import fetch_npc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [2:0]  nPC_sel,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4
);

  logic signed [31:0] br_off_s;
  logic        [31:0] br_target;
  logic        [31:0] jmp_target;
  logic               unused_opcode;

  // Opcode bits only matter to the decoder, not to target generation.
  assign unused_opcode = ^instr[31:26];

  assign pc_plus4   = pc + 32'd4;
  assign br_off_s   = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_target  = pc_plus4 + $unsigned(br_off_s);
  assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (nPC_sel)
      NPC_BEQ: npc = zero  ? br_target : pc_plus4;
      NPC_BNE: npc = !zero ? br_target : pc_plus4;
      NPC_J,
      NPC_JAL: npc = jmp_target;
      NPC_JR:  npc = rs_data;
      default: npc = pc_plus4;  // seq, plus the unused 110/111 codes
    endcase
  end

endmodule

// File: rtl/fetch_npc_unit.sv
// Instruction fetch and next-PC stage.
// Fetches the word at pc over a req/ready handshake (S_REQ), presents it for
// one execute window (S_EXEC, extendable by stall), then commits the next PC
// and bumps the retired counter. A misaligned next PC (only reachable via jr)
// parks the unit in S_HALT until reset.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   imem_req/imem_addr          : fetch request and byte address (= pc)
//   imem_ready/imem_rdata       : memory response
//   instr/instr_valid           : current instruction and execute window flag
//   stall                       : hold the execute window
//   nPC_sel/zero/rs_data        : next-PC control inputs
//   pc/pc_plus4                 : current PC and jal link value
//   retired                     : committed instruction count (wraps)
//   halted                      : sticky misaligned-target flag
module fetch_npc_unit
  import fetch_npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             stall,
  input  logic [2:0]       nPC_sel,
  input  logic             zero,
  input  logic [31:0]      rs_data,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic [31:0]      npc;

  fetch_npc_unit_npc_calc u_npc_calc (
    .pc       (pc_q),
    .instr    (instr_q),
    .nPC_sel  (nPC_sel),
    .zero     (zero),
    .rs_data  (rs_data),
    .npc      (npc),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (npc[1:0] != 2'b00) begin
            // Misaligned target: freeze pc/retired and stop fetching.
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d      = npc;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end

  // Request is masked while reset is held so nothing is fetched mid-reset.
  assign imem_req    = (state_q == S_REQ) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_npc_unit.sv
module tb_fetch_npc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic [2:0]  nPC_sel = 3'd0;
  logic        zero = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        halted;

  int errors = 0;
  int checks = 0;

  fetch_npc_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .nPC_sel     (nPC_sel),
    .zero        (zero),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting for fetch, 1 = executing, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_ret = 32'd0;
  logic        m_halt = 1'b0;
  logic [31:0] m_npc;

  function automatic logic [31:0] model_npc(input logic [31:0] pc_v, input logic [31:0] ins,
                                            input logic [2:0] sel, input logic z,
                                            input logic [31:0] rs);
    logic [31:0] seqv;
    logic [31:0] br;
    int          off;
    seqv = pc_v + 32'd4;
    off  = 4 * int'($signed(ins[15:0]));
    br   = seqv + 32'(off);
    case (sel)
      3'd1:    return z ? br : seqv;
      3'd2:    return z ? seqv : br;
      3'd3,
      3'd4:    return {seqv[31:28], ins[25:0], 2'b00};
      3'd5:    return rs;
      default: return seqv;
    endcase
  endfunction

  assign m_npc = model_npc(m_pc, m_instr, nPC_sel, zero, rs_data);

  always @(posedge clk) begin
    if (reset) begin
      m_mode  <= 0;
      m_pc    <= RST_PC;
      m_instr <= 32'd0;
      m_ret   <= 32'd0;
      m_halt  <= 1'b0;
    end else if (m_mode == 0) begin
      if (imem_ready) begin
        m_instr <= imem_rdata;
        m_mode  <= 1;
      end
    end else if (m_mode == 1) begin
      if (!stall) begin
        if (m_npc % 4 != 0) begin
          m_halt <= 1'b1;
          m_mode <= 2;
        end else begin
          m_pc   <= m_npc;
          m_ret  <= m_ret + 32'd1;
          m_mode <= 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_req",    32'(imem_req),    32'((m_mode == 0) && !reset));
    chk("cmp_addr",   imem_addr,        m_pc);
    chk("cmp_valid",  32'(instr_valid), 32'(m_mode == 1));
    chk("cmp_instr",  instr,            m_instr);
    chk("cmp_pc",     pc,               m_pc);
    chk("cmp_pc4",    pc_plus4,         m_pc + 32'd4);
    chk("cmp_ret",    retired,          m_ret);
    chk("cmp_halted", 32'(halted),      32'(m_halt));
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  // Fetch one word (ready already high on entry) and execute it without stall.
  task automatic run_instr(input logic [31:0] ins, input logic [2:0] sel,
                           input logic z, input logic [31:0] rs);
    imem_ready = 1'b1;
    imem_rdata = ins;
    nPC_sel    = sel;
    zero       = z;
    rs_data    = rs;
    stall      = 1'b0;
    next();
    imem_ready = 1'b0;
    next();
  endtask

  initial begin
    next();
    next();
    chk("rst_pc",      pc, RST_PC);
    chk("rst_instr",   instr, 32'd0);
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_req",     32'(imem_req), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted",  32'(halted), 32'd0);

    reset = 1'b0;
    #1;
    chk("req_after_rst", 32'(imem_req), 32'd1);
    chk("addr0", imem_addr, 32'h0000_3000);

    run_instr(32'h0000_0001, 3'd0, 1'b0, 32'd0);
    chk("addr1", imem_addr, 32'h0000_3004);
    run_instr(32'h0000_0002, 3'd0, 1'b0, 32'd0);
    chk("addr2", imem_addr, 32'h0000_3008);
    run_instr(32'h0000_0003, 3'd0, 1'b0, 32'd0);
    chk("retired3", retired, 32'd3);
    run_instr(32'h0000_0004, 3'd0, 1'b0, 32'd0);
    chk("pc_3010", pc, 32'h0000_3010);

    // beq with offset -1 taken: loops back to itself.
    run_instr(32'h1022_FFFF, 3'd1, 1'b1, 32'd0);
    chk("beq_taken", pc, 32'h0000_3010);
    // bne with offset 2, not equal: 3014 + 8.
    run_instr(32'h1422_0002, 3'd2, 1'b0, 32'd0);
    chk("bne_taken", pc, 32'h0000_301C);
    run_instr(32'h0000_0005, 3'd0, 1'b0, 32'd0);
    chk("pc_3020", pc, 32'h0000_3020);

    // jal: link value visible during execute, target from instr[25:0].
    imem_ready = 1'b1;
    imem_rdata = {6'h03, 26'h000_0C40};
    nPC_sel    = 3'd4;
    next();
    imem_ready = 1'b0;
    chk("jal_link",  pc_plus4, 32'h0000_3024);
    chk("jal_valid", 32'(instr_valid), 32'd1);
    next();
    chk("jal_target", pc, 32'h0000_3100);

    run_instr(32'h03E0_0008, 3'd5, 1'b0, 32'h0000_3024);
    chk("jr_target", pc, 32'h0000_3024);
    run_instr(32'h1022_FFFF, 3'd1, 1'b0, 32'd0);
    chk("beq_not_taken", pc, 32'h0000_3028);

    // Memory not ready: request and address held.
    imem_ready = 1'b0;
    nPC_sel    = 3'd0;
    for (int i = 0; i < 3; i++) begin
      next();
      chk("wait_req",  32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h0000_3028);
    end

    // Stall the execute window for two extra cycles.
    imem_ready = 1'b1;
    imem_rdata = 32'hA5A5_0000;
    stall      = 1'b1;
    next();
    imem_ready = 1'b0;
    next();
    next();
    chk("stall_pc",    pc, 32'h0000_3028);
    chk("stall_instr", instr, 32'hA5A5_0000);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_ret",   retired, 32'd10);
    stall = 1'b0;
    next();
    chk("after_stall_pc",  pc, 32'h0000_302C);
    chk("after_stall_ret", retired, 32'd11);

    // Address wrap-around, sequential and negative branch.
    run_instr(32'h03E0_0008, 3'd5, 1'b0, 32'hFFFF_FFFC);
    chk("pc_top", pc, 32'hFFFF_FFFC);
    run_instr(32'h0000_0006, 3'd0, 1'b0, 32'd0);
    chk("seq_wrap", pc, 32'h0000_0000);
    run_instr(32'h1022_FFF0, 3'd1, 1'b1, 32'd0);
    chk("beq_wrap", pc, 32'hFFFF_FFC4);

    // Misaligned jr target halts the unit.
    run_instr(32'h03E0_0008, 3'd5, 1'b0, 32'h0000_3002);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc",   pc, 32'hFFFF_FFC4);
    chk("halt_ret",  retired, 32'd14);
    imem_ready = 1'b1;
    next();
    next();
    chk("halt_req",   32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);

    // Reset leaves S_HALT and restarts fetching.
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    chk("unhalt_pc",  pc, 32'h0000_3000);
    chk("unhalt_flg", 32'(halted), 32'd0);
    chk("unhalt_req", 32'(imem_req), 32'd1);
    run_instr(32'h1234_5678, 3'd0, 1'b0, 32'd0);
    chk("resume_pc",  pc, 32'h0000_3004);
    chk("resume_ret", retired, 32'd1);

    // Reset during a ready fetch: the word is dropped.
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    next();
    chk("rreq_instr", instr, 32'd0);
    chk("rreq_pc",    pc, RST_PC);
    chk("rreq_ret",   retired, 32'd0);
    reset = 1'b0;
    next();
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
